stream_serializer: RTL and testbench
====================================

# stream_serializer

Producer-side endpoint for the team's 1-bit valid/ready stream. It accepts a WIDTH-bit parallel word on a valid/ready input port and emits it one bit per handshake on a 1-bit valid/ready output port, marking the final bit with a last flag. It sits upstream of the 1-bit valid/ready pipeline stages and drives the first stage of the chain. Back-to-back words stream with no bubble cycles.

## Interface
- WIDTH, 8: bits per word; legal range is WIDTH >= 2.
- MSB_FIRST, 1: 1 sends word_data[WIDTH-1] first; 0 sends word_data[0] first.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- word_valid  in  1  a parallel word is offered.
- word_data  in  WIDTH  parallel word; sampled only on the word handshake.
- word_ready  out  1  the block can accept a word this cycle.
- bit_valid  out  1  bit_data holds a valid bit.
- bit_data  out  1  current serial bit.
- bit_last  out  1  the current bit is the final bit of its word.
- bit_ready  in  1  the downstream stage accepts the bit.
- busy  out  1  a word is in flight; equal to bit_valid.

## Operation
- State:
  - shift register sh[WIDTH-1:0];
  - bit counter cnt, $clog2(WIDTH) bits, counting 0..WIDTH-1;
  - valid register v.
- Handshakes:
  - word handshake: word_valid && word_ready;
  - bit handshake: bit_valid && bit_ready.
- States:
  - IDLE when v=0;
  - SHIFT when v=1.
- Combinational outputs:
  - bit_valid = v; busy = v;
  - bit_data = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  - bit_last = v && (cnt == WIDTH-1);
  - word_ready = ~v || (bit_last && bit_ready).
- Sequential update, in priority order:
  1. Word handshake: sh <= word_data, cnt <= 0, v <= 1.
  2. Else, bit handshake with bit_last=0: sh shifts toward the output end and zero-fills the vacated bit; cnt <= cnt+1. The shift is left when MSB_FIRST=1 and right when MSB_FIRST=0.
  3. Else, bit handshake with bit_last=1: v <= 0 and the block returns to IDLE.
  4. Else: hold all state.
- Simultaneous last-bit handshake and word handshake: the new word loads in the same edge, v stays 1, and no idle cycle occurs.
- word_valid while in SHIFT and not on the last bit: word_ready=0. Upstream must hold its word, and nothing is sampled.
- cnt never exceeds WIDTH-1. The wrap from WIDTH-1 happens only through a load (case 1) or the return to IDLE (case 3).
- Reset: v=0, sh=0, cnt=0.
  - Outputs during and after reset: bit_valid=0, bit_data=0, bit_last=0, busy=0, word_ready=1.
  - A reset mid-word discards the remaining bits. No partial word or last flag is emitted afterwards.

## Timing
- Load latency: a word handshake at edge N gives bit_valid=1 with the first bit in the cycle after edge N.
- Word duration: with bit_ready held at 1, a word occupies exactly WIDTH cycles, and bit_last is high in the WIDTH-th cycle.
- Sustained throughput: 1 bit/cycle across consecutive words, provided word_valid is high when bit_last && bit_ready.
- Stall rule: while bit_valid && !bit_ready, bit_data and bit_last remain stable and bit_valid remains 1. bit_valid deasserts only after a bit handshake on the last bit.
- word_ready depends combinationally on bit_ready; there is no combinational path from word_valid to any output.
- Reset assertion forces bit_valid low asynchronously. The first load after deassertion can occur at the first rising edge.

## Test plan
- Reset values: assert rst mid-stream, then release -> bit_valid=0, bit_last=0, busy=0, word_ready=1 immediately; the next word starts at bit 0.
- Single word: WIDTH=8, MSB_FIRST=1, word 0xA5, bit_ready=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; bit_last high only on the 8th; bit_valid=0 on the 9th.
- Back-to-back words: 0xA5 then 0x3C, word_valid held high, bit_ready=1 -> 16 consecutive valid cycles with no gap; second word reads 0,0,1,1,1,1,0,0; word_ready pulses only in the last-bit cycle.
- Backpressure: bit_ready low for 3 cycles after bit 3 of 0xA5 -> bit_data=0 and bit_valid=1 held for all 3 cycles; the full sequence remains intact; total duration 11 cycles.
- Bit ordering: MSB_FIRST=0, word 0x01 -> bits 1,0,0,0,0,0,0,0; bit_last on the 8th.
- Word offered while busy: word_valid=1 with 0x3C during bit 2 of 0xA5 -> word_ready=0 until the last-bit handshake; 0x3C is loaded at that edge, not earlier.

Source files
------------

// File: rtl/stream_serializer_if.sv
// Handshake bundle between a word producer, the serializer and the 1-bit stream consumer.
// The serializer takes the slave view; the environment driving it takes the master view.
interface stream_serializer_if #(
  parameter int WIDTH = 8
);
  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic             word_ready;
  logic             bit_valid;
  logic             bit_data;
  logic             bit_last;
  logic             bit_ready;
  logic             busy;

  modport master (
    output word_valid, word_data, bit_ready,
    input  word_ready, bit_valid, bit_data, bit_last, busy
  );

  modport slave (
    input  word_valid, word_data, bit_ready,
    output word_ready, bit_valid, bit_data, bit_last, busy
  );
endinterface

// File: rtl/stream_serializer.sv
// Parallel-to-serial stream endpoint: loads a WIDTH-bit word and emits one bit per
// valid/ready handshake, flagging the final bit; back-to-back words have no bubble.
module stream_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  stream_serializer_if.slave  s
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             v, last, wr, word_hs, bit_hs;
  logic [WIDTH-1:0] sh_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  // The output end is the MSB when MSB_FIRST, so shift toward it and zero-fill behind.
  assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  always_comb begin
    v       = (state_q == SHIFT);
    last    = v && (cnt_q == CNT_LAST);
    bit_hs  = v && s.bit_ready;
    wr      = ~v || (last && s.bit_ready);
    word_hs = s.word_valid && wr;
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    if (word_hs) begin
      // Also covers the last-bit handshake: the next word replaces it with no idle cycle.
      state_d = SHIFT;
      sh_d    = s.word_data;
      cnt_d   = '0;
    end else if (bit_hs && !last) begin
      sh_d  = sh_next;
      cnt_d = cnt_q + CW'(1);
    end else if (bit_hs) begin
      state_d = IDLE;
    end
  end

  assign s.bit_valid  = v;
  assign s.busy       = v;
  assign s.bit_data   = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign s.bit_last   = last;
  assign s.word_ready = wr;
endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: an MSB-first and an LSB-first instance share one stimulus;
// a queue model of pending bits is compared every cycle, plus directed literal checks.
module tb_stream_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wv  = 1'b0;
  logic [W-1:0] wd  = '0;
  logic         br  = 1'b1;
  int           n_pass = 0;
  int           n_tot  = 0;

  stream_serializer_if #(.WIDTH(W)) sif_m ();
  stream_serializer_if #(.WIDTH(W)) sif_l ();

  assign sif_m.word_valid = wv;
  assign sif_m.word_data  = wd;
  assign sif_m.bit_ready  = br;
  assign sif_l.word_valid = wv;
  assign sif_l.word_data  = wd;
  assign sif_l.bit_ready  = br;

  stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .s(sif_m));
  stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .s(sif_l));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: every accepted word expands into W pending bits; a bit handshake pops one.
  typedef struct {logic m; logic l;} bit_t;
  bit_t q[$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) q.delete();
    else begin
      logic exp_wr;
      bit_t b;
      exp_wr = (q.size() == 0) || (q.size() == 1 && br);
      if (q.size() > 0 && br) void'(q.pop_front());
      if (wv && exp_wr)
        for (int i = 0; i < W; i++) begin
          b.m = wd[W-1-i];
          b.l = wd[i];
          q.push_back(b);
        end
    end
  end

  initial forever begin
    logic ev, el, ew;
    @(negedge clk);
    if (rst) begin
      ev = 1'b0; el = 1'b0; ew = 1'b1;
      chk("rst_m_data", 32'(sif_m.bit_data), 32'(0));
      chk("rst_l_data", 32'(sif_l.bit_data), 32'(0));
    end else begin
      ev = (q.size() > 0);
      el = (q.size() == 1);
      ew = !ev || (el && br);
      if (ev) begin
        chk("m_data", 32'(sif_m.bit_data), 32'(q[0].m));
        chk("l_data", 32'(sif_l.bit_data), 32'(q[0].l));
      end
    end
    chk("m_valid", 32'(sif_m.bit_valid), 32'(ev));
    chk("m_busy",  32'(sif_m.busy),      32'(ev));
    chk("m_last",  32'(sif_m.bit_last),  32'(el));
    chk("m_wr",    32'(sif_m.word_ready), 32'(ew));
    chk("l_valid", 32'(sif_l.bit_valid), 32'(ev));
    chk("l_last",  32'(sif_l.bit_last),  32'(el));
    chk("l_wr",    32'(sif_l.word_ready), 32'(ew));
  end

  logic sv, sd, sl, swr, sdl;

  task automatic cyc();
    @(negedge clk);
    sv  = sif_m.bit_valid;
    sd  = sif_m.bit_data;
    sl  = sif_m.bit_last;
    swr = sif_m.word_ready;
    sdl = sif_l.bit_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] vv, dd, ll, ww, dl, stv, std, stl;
    int nh;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(sif_m.bit_valid), 32'(0));
    chk("rst_busy",  32'(sif_m.busy),      32'(0));
    chk("rst_last",  32'(sif_m.bit_last),  32'(0));
    chk("rst_wr",    32'(sif_m.word_ready), 32'(1));
    rst = 1'b0;

    // single word
    wv = 1'b1; wd = 8'hA5; cyc();
    chk("t1_wr_idle", 32'(swr), 32'(1));
    wv = 1'b0; vv = 0; dd = 0; ll = 0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      vv = {vv[30:0], sv}; ll = {ll[30:0], sl};
      if (k < 8) dd = {dd[30:0], sd};
    end
    chk("t1_data",  dd, 32'hA5);
    chk("t1_valid", vv, 32'h1FE);
    chk("t1_last",  ll, 32'h002);

    // back-to-back words
    wv = 1'b1; wd = 8'hA5; cyc();
    wd = 8'h3C; vv = 0; dd = 0; ll = 0; ww = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 8) wv = 1'b0;
      cyc();
      vv = {vv[30:0], sv}; ll = {ll[30:0], sl};
      if (k < 16) begin dd = {dd[30:0], sd}; ww = {ww[30:0], swr}; end
    end
    chk("t2_data",  dd, 32'hA53C);
    chk("t2_valid", vv, 32'h1FFFE);
    chk("t2_last",  ll, 32'h00202);
    chk("t2_wr",    ww, 32'h0101);

    // backpressure for 3 cycles after bit 3
    wv = 1'b1; wd = 8'hA5; cyc();
    wv = 1'b0; vv = 0; dd = 0; ll = 0; stv = 0; std = 0; stl = 0; nh = 0;
    for (int k = 0; k < 12; k++) begin
      br = !(k >= 4 && k <= 6);
      cyc();
      vv = {vv[30:0], sv}; ll = {ll[30:0], sl};
      if (sv && br) begin dd = {dd[30:0], sd}; nh++; end
      if (!br) begin stv = {stv[30:0], sv}; std = {std[30:0], sd}; stl = {stl[30:0], sl}; end
    end
    br = 1'b1;
    chk("t3_data",     dd, 32'hA5);
    chk("t3_nbits",    32'(nh), 32'd8);
    chk("t3_valid",    vv, 32'hFFE);
    chk("t3_last",     ll, 32'h002);
    chk("t3_stall_v",  stv, 32'h7);
    chk("t3_stall_d",  std, 32'h0);
    chk("t3_stall_l",  stl, 32'h0);

    // word offered while busy
    wv = 1'b1; wd = 8'hA5; cyc();
    wv = 1'b0; vv = 0; dd = 0; ww = 0;
    for (int k = 0; k < 17; k++) begin
      wv = (k >= 2 && k <= 7);
      if (k >= 2) wd = 8'h3C;
      cyc();
      vv = {vv[30:0], sv};
      if (k < 16) begin dd = {dd[30:0], sd}; ww = {ww[30:0], swr}; end
    end
    wv = 1'b0;
    chk("t4_data",  dd, 32'hA53C);
    chk("t4_wr",    ww, 32'h0101);
    chk("t4_valid", vv, 32'h1FFFE);

    // bit ordering on both instances
    wv = 1'b1; wd = 8'h01; cyc();
    wv = 1'b0; dd = 0; dl = 0; ll = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      dd = {dd[30:0], sd}; dl = {dl[30:0], sdl}; ll = {ll[30:0], sl};
    end
    chk("t5_msb_data", dd, 32'h01);
    chk("t5_lsb_data", dl, 32'h80);
    chk("t5_last",     ll, 32'h01);

    // reset in the middle of a word
    wv = 1'b1; wd = 8'hA5; cyc();
    wv = 1'b0;
    repeat (3) cyc();
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(sif_m.bit_valid), 32'(0));
    chk("t6_busy",  32'(sif_m.busy),      32'(0));
    chk("t6_last",  32'(sif_m.bit_last),  32'(0));
    chk("t6_wr",    32'(sif_m.word_ready), 32'(1));
    chk("t6_data",  32'(sif_m.bit_data),  32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("t6_idle", 32'(sv), 32'(0));
    wv = 1'b1; wd = 8'h3C; cyc();
    wv = 1'b0; dd = 0; ll = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      dd = {dd[30:0], sd}; ll = {ll[30:0], sl};
    end
    chk("t6_next_data", dd, 32'h3C);
    chk("t6_next_last", ll, 32'h01);

    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
